mac_accumulator: RTL

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 111 +++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: sums num_terms products, then holds the result.
// Define MAC_ACC_SATURATE_EN to clamp at 2^acc_w-1 instead of wrapping.
module mac_accumulator #(
   parameter int nbit      = 12,
   parameter int acc_w     = 26,
   parameter int num_terms = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2*nbit-1:0] in_product,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              clear,
   output logic [acc_w-1:0]  out_acc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow
);

   localparam int cnt_w = (num_terms > 2) ? $clog2(num_terms) : 1;
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_terms - 1);
   localparam int pad_w = acc_w + 1 - 2 * nbit;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [acc_w-1:0] acc;
   logic [cnt_w-1:0] cnt;
   logic             ovf;
   logic [acc_w:0]   sum_ext;
   logic [acc_w-1:0] sum_nxt;
   logic             carry;
   logic             accept;
   logic             last_term;
   logic             take;

   assign accept    = in_valid && in_ready;
   assign last_term = accept && (cnt == last_cnt);
   assign take      = out_valid && out_ready;

   assign sum_ext = {1'b0, acc} + {{pad_w{1'b0}}, in_product};
   assign carry   = sum_ext[acc_w];

`ifdef MAC_ACC_SATURATE_EN
   // Once saturated, the sum stays pinned at full scale until the result leaves.
   assign sum_nxt = (carry || ovf) ? {acc_w{1'b1}} : sum_ext[acc_w-1:0];
`else
   assign sum_nxt = sum_ext[acc_w-1:0];
`endif

   assign overflow = ovf;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACC;
      else     state <= state_nxt;
   end

   // Next state: clear wins, otherwise collect then hold until taken.
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = ACC;
      end else begin
         unique case (state)
            ACC:  if (last_term) state_nxt = HOLD;
            HOLD: if (take)      state_nxt = ACC;
            default: state_nxt = ACC;
         endcase
      end
   end

   // Handshake outputs are pure decodes of the registered state.
   always_comb begin
      in_ready  = (state == ACC);
      out_valid = (state == HOLD);
   end

   // Accumulator, term counter, sticky overflow and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         out_acc <= '0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (accept) begin
         acc <= sum_nxt;
         ovf <= ovf | carry;
         if (last_term) begin
            out_acc <= sum_nxt;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if (take) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end

endmodule
